// File: rtl/alu_sequencer.sv
// Sequencer that accepts one request over a start/done handshake and drives the
// ALU ld/opLd/exe/out strobe sequence, capturing the 16-bit result and carry.
module alu_sequencer #(
    parameter int unsigned EXE_CYCLES = 2,
    parameter int unsigned OUT_CYCLES = 1,
    parameter logic [5:0]  MAX_OP     = 6'h11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  opcode,
    input  logic [7:0]  op_a,
    input  logic [7:0]  op_b,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_ld,
    output logic        alu_opld,
    output logic        alu_exe,
    output logic        alu_out,
    input  logic [15:0] alu_res,
    input  logic        alu_carry,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        carry,
    output logic        err
);

    localparam int unsigned MAX_CYC = (EXE_CYCLES > OUT_CYCLES) ? EXE_CYCLES : OUT_CYCLES;
    localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] EXE_LOAD = CW'(EXE_CYCLES - 1);
    localparam logic [CW-1:0] OUT_LOAD = CW'(OUT_CYCLES - 1);

    // REJECT spends one cycle on an illegal opcode so done/err land one edge after acceptance.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_OPLD   = 3'd2,
        S_EXEC   = 3'd3,
        S_OUT    = 3'd4,
        S_DONE   = 3'd5,
        S_REJECT = 3'd6
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    opc_q, opc_d;
    logic [7:0]    a_q, a_d;
    logic [7:0]    b_q, b_d;
    logic          accept_s;
    logic          legal_s;

    logic [7:0]    alu_a_q, alu_a_d;
    logic [7:0]    alu_b_q, alu_b_d;
    logic          alu_ld_q, alu_ld_d;
    logic          alu_opld_q, alu_opld_d;
    logic          alu_exe_q, alu_exe_d;
    logic          alu_out_q, alu_out_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [15:0]   result_q, result_d;
    logic          carry_q, carry_d;
    logic          err_q, err_d;

    assign accept_s = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign legal_s  = (opcode <= MAX_OP);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = legal_s ? S_LOAD : S_REJECT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD:   state_d = S_OPLD;
            S_OPLD:   state_d = S_EXEC;
            S_EXEC: begin
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = S_OUT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_OUT: begin
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_OUT;
                end
            end
            S_REJECT: state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Dwell counter and request latches.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            case (state_d)
                S_EXEC:  cnt_d = EXE_LOAD;
                S_OUT:   cnt_d = OUT_LOAD;
                default: cnt_d = {CW{1'b0}};
            endcase
        end else if (cnt_q != {CW{1'b0}}) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            cnt_d = cnt_q;
        end

        if (accept_s) begin
            opc_d = opcode;
            a_d   = op_a;
            b_d   = op_b;
        end else begin
            opc_d = opc_q;
            a_d   = a_q;
            b_d   = b_q;
        end
    end

    // Counter and latched-request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CW{1'b0}};
            opc_q <= 6'h00;
            a_q   <= 8'h00;
            b_q   <= 8'h00;
        end else begin
            cnt_q <= cnt_d;
            opc_q <= opc_d;
            a_q   <= a_d;
            b_q   <= b_d;
        end
    end

    // Output decode from the upcoming state so every output is a flop.
    always_comb begin
        alu_a_d    = 8'h00;
        alu_b_d    = 8'h00;
        alu_ld_d   = 1'b0;
        alu_opld_d = 1'b0;
        alu_exe_d  = 1'b0;
        alu_out_d  = 1'b0;
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        case (state_d)
            S_LOAD: begin
                alu_a_d  = a_d;
                alu_b_d  = b_d;
                alu_ld_d = 1'b1;
            end
            S_OPLD: begin
                alu_a_d    = a_d;
                alu_b_d    = {2'b00, opc_d};
                alu_opld_d = 1'b1;
            end
            S_EXEC: begin
                alu_a_d   = a_d;
                alu_b_d   = {2'b00, opc_d};
                alu_exe_d = 1'b1;
            end
            S_OUT: begin
                alu_a_d   = a_d;
                alu_b_d   = {2'b00, opc_d};
                alu_exe_d = 1'b1;
                alu_out_d = 1'b1;
            end
            default: begin
                alu_a_d = 8'h00;
                alu_b_d = 8'h00;
            end
        endcase

        if (accept_s) begin
            err_d = 1'b0;
        end else if (state_q == S_REJECT) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end

        if ((state_q == S_OUT) && (state_d == S_DONE)) begin
            result_d = alu_res;
            carry_d  = alu_carry;
        end else begin
            result_d = result_q;
            carry_d  = carry_q;
        end
    end

    // Output registers; reset clears every strobe at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q    <= 8'h00;
            alu_b_q    <= 8'h00;
            alu_ld_q   <= 1'b0;
            alu_opld_q <= 1'b0;
            alu_exe_q  <= 1'b0;
            alu_out_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= 16'h0000;
            carry_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_ld_q   <= alu_ld_d;
            alu_opld_q <= alu_opld_d;
            alu_exe_q  <= alu_exe_d;
            alu_out_q  <= alu_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            err_q      <= err_d;
        end
    end

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_ld   = alu_ld_q;
    assign alu_opld = alu_opld_q;
    assign alu_exe  = alu_exe_q;
    assign alu_out  = alu_out_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign carry    = carry_q;
    assign err      = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed plus randomized bench for alu_sequencer with a small behavioural ALU
// attached to its strobes and an edge-indexed reference for every output.
module tb_alu_sequencer;

    localparam int E = 2;
    localparam int O = 1;
    localparam int L = 2 + E + O;
    localparam logic [5:0] OP_ADD = 6'h00;
    localparam logic [5:0] OP_SUB = 6'h01;
    localparam logic [5:0] OP_AND = 6'h02;
    localparam logic [5:0] OP_XOR = 6'h04;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  opcode;
    logic [7:0]  op_a, op_b;
    logic [7:0]  alu_a, alu_b;
    logic        alu_ld, alu_opld, alu_exe, alu_out;
    logic [15:0] alu_res;
    logic        alu_carry;
    logic        busy, done, carry, err;
    logic [15:0] result;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_res;
    logic        exp_carry;
    logic [7:0]  ma, mb;
    logic [5:0]  mop;

    alu_sequencer #(.EXE_CYCLES(E), .OUT_CYCLES(O), .MAX_OP(6'h11)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
        .op_a(op_a), .op_b(op_b), .alu_a(alu_a), .alu_b(alu_b),
        .alu_ld(alu_ld), .alu_opld(alu_opld), .alu_exe(alu_exe), .alu_out(alu_out),
        .alu_res(alu_res), .alu_carry(alu_carry), .busy(busy), .done(done),
        .result(result), .carry(carry), .err(err)
    );

    always #5 clk = ~clk;

    // Returns {carry, result} for an operation.
    function automatic logic [16:0] alu_fn(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] s;
        s = {8'h00, a} + {8'h00, b};
        case (op)
            6'h00:   return {s[8], s};
            6'h01:   return {(a < b), 8'h00, a - b};
            6'h02:   return {1'b0, 8'h00, a & b};
            6'h03:   return {1'b0, 8'h00, a | b};
            6'h04:   return {1'b0, 8'h00, a ^ b};
            default: return {^a, 2'b00, op, a ^ b};
        endcase
    endfunction

    // Behavioural ALU: operands on ld, opcode on opLd, result only while exe and out.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma  <= 8'h00;
            mb  <= 8'h00;
            mop <= 6'h00;
        end else begin
            if (alu_ld) begin
                ma <= alu_a;
                mb <= alu_b;
            end
            if (alu_opld) mop <= alu_b[5:0];
        end
    end
    assign {alu_carry, alu_res} = (alu_exe && alu_out) ? alu_fn(mop, ma, mb) : {1'b0, 16'hDEAD};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one request, checking every output #1 after each edge k counted from the accepting edge.
    task automatic do_op(input logic [5:0] opc, input logic [7:0] a, input logic [7:0] b,
                         input bit pre, input int poke, input bit chain,
                         input logic [5:0] nopc, input logic [7:0] na, input logic [7:0] nb);
        bit          legal;
        int          last;
        logic [16:0] r;
        logic [15:0] prev_res;
        logic        prev_carry;
        logic [3:0]  exp_strb;
        legal      = (opc <= 6'h11);
        last       = legal ? L : 1;
        prev_res   = exp_res;
        prev_carry = exp_carry;
        if (legal) begin
            r         = alu_fn(opc, a, b);
            exp_res   = r[15:0];
            exp_carry = r[16];
        end
        if (!pre) begin
            @(negedge clk);
            start = 1'b1; opcode = opc; op_a = a; op_b = b;
        end
        @(posedge clk);
        #1;
        start  = 1'b0;
        opcode = 6'($urandom);
        op_a   = 8'($urandom);
        op_b   = 8'($urandom);
        for (int k = 0; k <= (chain ? last : last + 1); k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            exp_strb = legal ? {k == 0, k == 1, (k >= 2) && (k < L), (k >= 2 + E) && (k < L)} : 4'b0000;
            chk("strobes", {12'h000, alu_ld, alu_opld, alu_exe, alu_out}, {12'h000, exp_strb});
            chk("alu_a", {8'h00, alu_a}, (legal && k < L) ? {8'h00, a} : 16'h0000);
            chk("alu_b", {8'h00, alu_b}, (!legal || k >= L) ? 16'h0000 : ((k == 0) ? {8'h00, b} : {10'h000, opc}));
            chk("done", {15'h0000, done}, {15'h0000, k == last});
            chk("busy", {15'h0000, busy}, {15'h0000, k <= last});
            chk("err", {15'h0000, err}, {15'h0000, !legal && (k >= 1)});
            chk("result", result, (k >= last) ? exp_res : prev_res);
            chk("carry", {15'h0000, carry}, {15'h0000, (k >= last) ? exp_carry : prev_carry});
            if (k == poke) begin
                start = 1'b1; opcode = OP_AND; op_a = 8'h3C; op_b = 8'h0F;
            end else if (k == poke + 1) begin
                start = 1'b0;
            end
            if (chain && (k == last - 1)) begin
                start = 1'b1; opcode = nopc; op_a = na; op_b = nb;
            end
        end
    endtask

    initial begin
        logic [5:0] ropc;
        logic [7:0] ra, rb;
        rst_n = 1'b1; start = 1'b0; opcode = 6'h00; op_a = 8'h00; op_b = 8'h00;
        exp_res = 16'h0000; exp_carry = 1'b0;
        #1 rst_n = 1'b0;
        #10;
        chk("reset_strobes", {12'h000, alu_ld, alu_opld, alu_exe, alu_out}, 16'h0000);
        chk("reset_bus", {alu_a, alu_b}, 16'h0000);
        chk("reset_flags", {12'h000, busy, done, carry, err}, 16'h0000);
        chk("reset_result", result, 16'h0000);

        // First start is sampled on the first edge after release.
        @(negedge clk);
        rst_n = 1'b1; start = 1'b1; opcode = OP_ADD; op_a = 8'h08; op_b = 8'h04;
        do_op(OP_ADD, 8'h08, 8'h04, 1'b1, -1, 1'b0, 6'h00, 8'h00, 8'h00);
        chk("add_result", result, 16'h000C);

        do_op(OP_SUB, 8'h08, 8'h04, 1'b0, -1, 1'b0, 6'h00, 8'h00, 8'h00);
        chk("sub_result", result, 16'h0004);

        do_op(6'h12, 8'h55, 8'hAA, 1'b0, -1, 1'b0, 6'h00, 8'h00, 8'h00);
        chk("illegal_keeps_result", result, 16'h0004);

        // Start pulsed during EXEC is dropped.
        do_op(OP_ADD, 8'hFF, 8'h01, 1'b0, 2, 1'b0, 6'h00, 8'h00, 8'h00);
        chk("poke_result", {15'h0000, carry, result}, {15'h0001, 16'h0100});

        // Back-to-back: start held across OUT and DONE.
        do_op(OP_ADD, 8'hF0, 8'h0F, 1'b0, -1, 1'b1, OP_XOR, 8'hF0, 8'h0F);
        do_op(OP_XOR, 8'hF0, 8'h0F, 1'b1, -1, 1'b0, 6'h00, 8'h00, 8'h00);
        chk("xor_result", result, 16'h00FF);

        do_op(OP_SUB, 8'h03, 8'h05, 1'b0, -1, 1'b1, 6'h3F, 8'h11, 8'h22);
        do_op(6'h3F, 8'h11, 8'h22, 1'b1, -1, 1'b1, OP_ADD, 8'h12, 8'h34);
        do_op(OP_ADD, 8'h12, 8'h34, 1'b1, -1, 1'b0, 6'h00, 8'h00, 8'h00);

        // Asynchronous reset in the middle of EXEC.
        @(negedge clk);
        start = 1'b1; opcode = OP_ADD; op_a = 8'h08; op_b = 8'h04;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre_reset_exe", {15'h0000, alu_exe}, 16'h0001);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_reset_strobes", {12'h000, alu_ld, alu_opld, alu_exe, alu_out}, 16'h0000);
        chk("mid_reset_busy", {15'h0000, busy}, 16'h0000);
        chk("mid_reset_result", result, 16'h0000);
        chk("mid_reset_bus", {alu_a, alu_b}, 16'h0000);
        exp_res = 16'h0000; exp_carry = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; start = 1'b1; opcode = OP_ADD; op_a = 8'h08; op_b = 8'h04;
        do_op(OP_ADD, 8'h08, 8'h04, 1'b1, -1, 1'b0, 6'h00, 8'h00, 8'h00);
        chk("post_reset_add", result, 16'h000C);

        for (int i = 0; i < 24; i++) begin
            ropc = 6'($urandom_range(0, 19));
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            do_op(ropc, ra, rb, 1'b0, -1, 1'b0, 6'h00, 8'h00, 8'h00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
